ser_8b10b_tx: RTL

- Transmit-side counterpart of the link deserializer.
- Accepts 9-bit characters {K, byte} over a valid/ready handshake and 8b/10b-encodes them with the codebase's encode_8b10b.
  - encode_8b10b ports: datain[8:0], dispin, dataout[9:0], dispout.
- Shifts each 10-bit codeword out MSB-first (bit 9 = 'a'), one bit per clock.
- Inserts K28.5 idle commas whenever no character is offered, so the downstream deserializer always sees a legal, DC-balanced stream.

---
 rtl/ser_8b10b_tx_if.sv | 14 +
 rtl/ser_8b10b_tx.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ser_8b10b_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ser_8b10b_tx_if : character handshake into the 8b/10b serial TX      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface ser_8b10b_tx_if;
  logic [8:0] data_i;
  logic       valid_i;
  logic       ready_o;

  modport master (output data_i, output valid_i, input ready_o);
  modport slave  (input data_i, input valid_i, output ready_o);
endinterface
`default_nettype wire

// File: rtl/ser_8b10b_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ser_8b10b_tx : 8b/10b encoder + MSB-first serializer, K28.5 idle fill |
// | Optional macro SER_ERR_INJECT_EN adds inject_i (forced disparity err) |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ser_8b10b_tx #(
  parameter int         WIDTH     = 10,
  parameter logic [8:0] IDLE_CHAR = 9'h1BC
) (
  input  wire            clk_i,
  input  wire            rst_i,
  ser_8b10b_tx_if.slave  bus,
`ifdef SER_ERR_INJECT_EN
  input  wire            inject_i,
`endif
  output logic           serial_o,
  output logic           sob_o,
  output logic           kerr_o,
  output logic           rdisp_o
);

  if (WIDTH != 10) begin : g_width_check
    $error("ser_8b10b_tx: WIDTH must be 10");
  end

  logic [3:0]  cnt_q;
  logic [9:0]  shift_q;
  logic        rdisp_q;
  logic        kerr_q;

  logic [8:0]  sel_char;
  logic [8:0]  enc_char;
  logic        bad_k;
  logic        enc_din;
  logic [10:0] enc_out;

  function automatic logic legal_k(input logic [7:0] b);
    case (b)
      8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
      8'hF7, 8'hFB, 8'hFD, 8'hFE: legal_k = 1'b1;
      default:                    legal_k = 1'b0;
    endcase
  endfunction

  // Returns {dispout, abcdei, fghj}. Tables hold the RD- form; RD+ forms
  // are the complements of the disparity-carrying (and D.7 / D.x.3) codes.
  function automatic logic [10:0] encode_8b10b(input logic [8:0] datain,
                                               input logic       dispin);
    logic [4:0] x;
    logic [2:0] y;
    logic       k;
    logic       k28;
    logic [5:0] c6;
    logic [3:0] c4;
    logic       rd3;
    logic       a7;
    logic       dout;
    k   = datain[8];
    x   = datain[4:0];
    y   = datain[7:5];
    k28 = k && (x == 5'd28);
    c6  = 6'b000000;
    case (x)
      5'd0:  c6 = 6'b100111;  5'd1:  c6 = 6'b011101;
      5'd2:  c6 = 6'b101101;  5'd3:  c6 = 6'b110001;
      5'd4:  c6 = 6'b110101;  5'd5:  c6 = 6'b101001;
      5'd6:  c6 = 6'b011001;  5'd7:  c6 = 6'b111000;
      5'd8:  c6 = 6'b111001;  5'd9:  c6 = 6'b100101;
      5'd10: c6 = 6'b010101;  5'd11: c6 = 6'b110100;
      5'd12: c6 = 6'b001101;  5'd13: c6 = 6'b101100;
      5'd14: c6 = 6'b011100;  5'd15: c6 = 6'b010111;
      5'd16: c6 = 6'b011011;  5'd17: c6 = 6'b100011;
      5'd18: c6 = 6'b010011;  5'd19: c6 = 6'b110010;
      5'd20: c6 = 6'b001011;  5'd21: c6 = 6'b101010;
      5'd22: c6 = 6'b011010;  5'd23: c6 = 6'b111010;
      5'd24: c6 = 6'b110011;  5'd25: c6 = 6'b100110;
      5'd26: c6 = 6'b010110;  5'd27: c6 = 6'b110110;
      5'd28: c6 = 6'b001110;  5'd29: c6 = 6'b101110;
      5'd30: c6 = 6'b011110;  5'd31: c6 = 6'b101011;
      default: c6 = 6'b000000;
    endcase
    if (k28) c6 = 6'b001111;
    if (dispin && (($countones(c6) != 3) || (x == 5'd7))) c6 = ~c6;
    rd3 = ($countones(c6) == 3) ? dispin : ~dispin;

    // Alternate x.7 avoids a run of five equal bits across the sub-block seam.
    a7 = (y == 3'd7) && (k ||
         (!rd3 && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
         ( rd3 && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
    case (y)
      3'd0:    c4 = 4'b1011;
      3'd1:    c4 = 4'b1001;
      3'd2:    c4 = 4'b0101;
      3'd3:    c4 = 4'b1100;
      3'd4:    c4 = 4'b1101;
      3'd5:    c4 = 4'b1010;
      3'd6:    c4 = 4'b0110;
      default: c4 = a7 ? 4'b0111 : 4'b1110;
    endcase
    if (k28 && !rd3 && (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6))
      c4 = ~c4;
    if (rd3 && (($countones(c4) != 2) || (y == 3'd3))) c4 = ~c4;
    dout = ($countones(c4) == 2) ? rd3 : ~rd3;
    encode_8b10b = {dout, c6, c4};
  endfunction

  always_comb begin
    sel_char = bus.valid_i ? bus.data_i : IDLE_CHAR;
    bad_k    = sel_char[8] && !legal_k(sel_char[7:0]);
    enc_char = bad_k ? IDLE_CHAR : sel_char;
`ifdef SER_ERR_INJECT_EN
    enc_din  = rdisp_q ^ inject_i;
`else
    enc_din  = rdisp_q;
`endif
    enc_out  = encode_8b10b(enc_char, enc_din);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= 4'd9;
      shift_q <= 10'd0;
      rdisp_q <= 1'b0;
      kerr_q  <= 1'b0;
    end else if (cnt_q == 4'd9) begin
      shift_q <= enc_out[9:0];
      rdisp_q <= enc_out[10];
      cnt_q   <= 4'd0;
      kerr_q  <= bad_k;
    end else begin
      shift_q <= {shift_q[8:0], 1'b0};
      cnt_q   <= cnt_q + 4'd1;
      kerr_q  <= 1'b0;
    end
  end

  assign bus.ready_o = (cnt_q == 4'd9);
  assign serial_o    = shift_q[9];
  assign sob_o       = (cnt_q == 4'd0);
  assign kerr_o      = kerr_q;
  assign rdisp_o     = rdisp_q;

endmodule
`default_nettype wire
